// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with run/halt FSM, condition-coded branches and a return-address stack.
// Latency: a new PC is visible one cycle after the sampling posedge; stall freezes PC, state and stack.
// Optional PANDA_PC_BRANCH_COUNT_EN adds a saturating 16-bit taken-branch/call/return counter.
module pc_stack_unit #(
    parameter int PC_WIDTH    = 12,
    parameter int OFF_WIDTH   = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stall,
    input  logic                               eq,
    input  logic                               lt,
    input  logic                               gt,
    input  logic [2:0]                         cond_sel,
    input  logic                               abs_en,
    input  logic                               rel_en,
    input  logic [PC_WIDTH-1:0]                target,
    input  logic [OFF_WIDTH-1:0]               rel_offset,
    input  logic                               call_en,
    input  logic                               ret_en,
    input  logic                               halt_req,
    output logic [PC_WIDTH-1:0]                current_pc,
    output logic                               running,
    output logic                               halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_ovf,
    output logic                               stack_unf
`ifdef PANDA_PC_BRANCH_COUNT_EN
    ,
    output logic [15:0]                        branch_count
`endif
);
    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(STACK_DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, HALT} state_t;

    state_t                state;
    logic [PC_WIDTH-1:0]   stack_mem [STACK_DEPTH];
    logic                  cond_true;
    logic                  jump_en;
    logic                  stack_full;
    logic                  stack_empty;
    logic [LW-1:0]         lvl_dec;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   jump_dest;

    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = eq;
            3'b010:  cond_true = lt;
            3'b011:  cond_true = gt;
            3'b100:  cond_true = 1'b1;
            3'b101:  cond_true = !eq;
            3'b110:  cond_true = eq | lt;
            3'b111:  cond_true = eq | gt;
            default: cond_true = 1'b0;
        endcase
    end

    // Size-casting the signed offset sign-extends it, so relative jumps wrap both ways.
    assign jump_en     = cond_true && (abs_en || rel_en);
    assign jump_dest   = abs_en ? target : current_pc + PC_WIDTH'($signed(rel_offset));
    assign pc_inc      = current_pc + PC_WIDTH'(1);
    assign stack_full  = (stack_level == FULL_LVL);
    assign stack_empty = (stack_level == '0);
    assign lvl_dec     = stack_level - LW'(1);
    assign running     = (state == RUN);
    assign halted      = (state == HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            current_pc  <= '0;
            stack_level <= '0;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    current_pc <= '0;
                    if (start) state <= ARMED;
                end
                ARMED: begin
                    if (!start) state <= RUN;
                end
                RUN: begin
                    if (halt_req) begin
                        state <= HALT;
                    end else if (ret_en) begin
                        if (stack_empty) begin
                            stack_unf <= 1'b1;
                            state     <= HALT;
                        end else begin
                            current_pc  <= stack_mem[lvl_dec[IW-1:0]];
                            stack_level <= lvl_dec;
                        end
                    end else if (jump_en && call_en) begin
                        if (stack_full) begin
                            stack_ovf <= 1'b1;
                            state     <= HALT;
                        end else begin
                            stack_mem[stack_level[IW-1:0]] <= pc_inc;
                            stack_level <= stack_level + LW'(1);
                            current_pc  <= jump_dest;
                        end
                    end else if (jump_en) begin
                        current_pc <= jump_dest;
                    end else begin
                        current_pc <= pc_inc;
                    end
                end
                HALT: begin
                    if (start) begin
                        state       <= ARMED;
                        current_pc  <= '0;
                        stack_level <= '0;
                        stack_ovf   <= 1'b0;
                        stack_unf   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PANDA_PC_BRANCH_COUNT_EN
    logic branch_evt;
    logic restart;

    // Counts only transfers that actually change flow: failed calls/returns halt instead.
    assign branch_evt = (state == RUN) && !stall && !halt_req &&
                        (ret_en ? !stack_empty : (jump_en && !(call_en && stack_full)));
    assign restart    = (state == HALT) && !stall && start;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            branch_count <= '0;
        end else if (branch_evt && branch_count != 16'hFFFF) begin
            branch_count <= branch_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Next-generation program counter for the PANDA CPU fetch stage. Generalised successor to the single-mode PC:
- parametrised PC and offset widths
- eight condition codes
- subroutine call/return through a parametrised return-address stack
- run/halt state machine with start-hold semantics
- fetch stall
Sits between decode/compare logic and instruction memory address port.

Parameters:
PC_WIDTH, 12, width of program counter and branch target (PC arithmetic modulo 2^PC_WIDTH)
OFF_WIDTH, 6, width of signed relative branch offset (two's complement)
STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
clk  input  1  clock; all state changes on posedge only
reset  input  1  synchronous, active-high; forces IDLE, PC=0, stack empty, flags clear
start  input  1  testbench program start request; PC held while asserted
stall  input  1  freeze PC, state and stack this cycle
eq  input  1  compare flag equal
lt  input  1  compare flag less-than
gt  input  1  compare flag greater-than
cond_sel  input  3  000 never, 001 EQ, 010 LT, 011 GT, 100 always, 101 NE(!eq), 110 LE(eq|lt), 111 GE(eq|gt)
abs_en  input  1  taken branch/call goes to target
rel_en  input  1  taken branch/call goes to PC + sext(rel_offset)
target  input  PC_WIDTH  absolute destination
rel_offset  input  OFF_WIDTH  signed relative offset
call_en  input  1  branch is a call: push return address on take
ret_en  input  1  unconditional return: pop stack into PC
halt_req  input  1  stop execution
current_pc  output  PC_WIDTH  registered PC
running  output  1  state==RUN
halted  output  1  state==HALT
stack_level  output  $clog2(STACK_DEPTH+1)  occupied entries
stack_ovf  output  1  sticky: call attempted with stack full
stack_unf  output  1  sticky: return attempted with stack empty

Behaviour:
- Reset values: current_pc=0, state=IDLE, running=0, halted=0, stack_level=0, stack_ovf=0, stack_unf=0. Reset wins over every other input, in any state including mid-call.
- States: IDLE, ARMED, RUN, HALT.
- IDLE: start=1 -> ARMED. PC stays 0.
- ARMED: PC held while start=1. First cycle with start=0 -> RUN. PC still 0; first fetch at 0, increment begins the following cycle.
- HALT:
  - PC holds; stack and sticky flags hold.
  - start=1 -> ARMED, PC:=0, stack emptied, flags cleared.
- Stall: stall=1 in RUN freezes PC, stack and state; all other inputs ignored.
- RUN priority, highest first:
  1. stall
  2. halt_req -> HALT, PC holds
  3. ret_en:
     - stack empty -> stack_unf:=1, HALT, PC holds
     - otherwise PC:=top, pop
  4. taken (cond_sel decode true) with abs_en or rel_en:
     - abs_en takes precedence over rel_en when both are set
     - abs destination = target
     - rel destination = current_pc + sign-extended rel_offset, truncated to PC_WIDTH (wraps both ways)
     - with call_en: push current_pc+1 (mod 2^PC_WIDTH), then jump
     - call with stack full -> stack_ovf:=1, HALT, no push, PC holds
  5. otherwise PC:=current_pc+1, wrapping 2^PC_WIDTH-1 -> 0
- Taken condition with neither abs_en nor rel_en behaves as increment; call_en ignored.
- Condition not taken: call_en ignored; increment.
- Condition flags are sampled combinationally in the same cycle as the control inputs.
- Latency: new PC visible one cycle after the posedge that samples the controls.
- Stack is a LIFO:
  - push and pop never occur in the same cycle (ret has priority)
  - stack_level updates with the PC

Optional Feature:
PANDA_PC_BRANCH_COUNT_EN
- Defined:
  - adds output branch_count[15:0]
  - increments on every taken branch, call or successful return in RUN
  - saturates at 16'hFFFF
  - reset to 0 by reset and by the HALT->ARMED restart
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- reset; start=1 for 3 cycles; release -> PC 0,0,0,0 held, then 1,2,3; running=1 after release.
- RUN at PC=5, cond_sel=001, eq=1, rel_en, rel_offset=6'b111110 (-2) -> PC=3; same with eq=0 -> PC=6.
- PC_WIDTH=12, PC=12'hFFF, no branch -> PC=0. PC=1, rel_offset=-3 -> PC=12'hFFE.
- Call/return:
  - at PC=10: cond_sel=100, abs_en, call_en, target=40 -> PC=40, stack_level=1
  - later ret_en -> PC=11, stack_level=0
  - 5th nested call with STACK_DEPTH=4 -> stack_ovf=1, halted=1, PC unchanged
- ret_en with empty stack -> stack_unf=1, HALT. Then start pulse -> ARMED, PC=0, flags cleared.
- halt_req and ret_en together at PC=7 -> HALT, PC=7, stack unchanged.
- stall=1 for 2 cycles during a call -> no push, no PC change until released.
